// File: rtl/keypad_scan_fsm_if.sv
// keypad_scan_fsm_if: keypad matrix pins plus the decoded key outputs.
// The scanner takes the master view; the keypad/consumer side takes slave.
interface keypad_scan_fsm_if;
    logic [3:0] row;
    logic [3:0] col;
    logic       flag;
    logic [3:0] press_num;
    logic       key_held;
    modport master (input row, output col, flag, press_num, key_held);
    modport slave  (output row, input col, flag, press_num, key_held);
endinterface

// File: rtl/keypad_scan_fsm.sv
// keypad_scan_fsm: debounced 4x4 keypad scanner; one flag pulse per single-key press,
// then waits for a debounced release before scanning resumes on the next column.
module keypad_scan_fsm #(
    parameter int DWELL     = 4,
    parameter int DB_CYCLES = 20
) (
    input logic clk,
    input logic rst,
    keypad_scan_fsm_if.master kp
);
    localparam int CW = $clog2(DWELL > DB_CYCLES ? DWELL : DB_CYCLES);

    typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE} state_t;

    state_t        state_q, state_d;
    logic [3:0]    sync_q, row_s_q;
    logic [3:0]    col_q, col_d;
    logic [3:0]    row_cap_q, row_cap_d;
    logic [3:0]    press_num_q, press_num_d;
    logic          key_held_q, key_held_d;
    logic [CW-1:0] dwell_q, dwell_d, db_q, db_d, rel_q, rel_d;
    logic [3:0]    rs_n, col_rot;
    logic [1:0]    row_idx, col_idx;
    logic          one_key;

    assign rs_n    = ~row_s_q;
    assign one_key = (rs_n != 4'd0) && ((rs_n & (rs_n - 4'd1)) == 4'd0);
    assign col_rot = {col_q[2:0], col_q[3]};
    // encode the single low bit of a one-hot-low nibble
    assign row_idx = {~row_cap_q[3] | ~row_cap_q[2], ~row_cap_q[3] | ~row_cap_q[1]};
    assign col_idx = {~col_q[3] | ~col_q[2], ~col_q[3] | ~col_q[1]};

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_cap_d   = row_cap_q;
        press_num_d = press_num_q;
        key_held_d  = key_held_q;
        dwell_d     = dwell_q;
        db_d        = db_q;
        rel_d       = rel_q;
        case (state_q)
            SCAN: begin
                if (dwell_q != CW'(DWELL - 1)) begin
                    dwell_d = dwell_q + 1'b1;
                end else if (one_key) begin
                    row_cap_d = row_s_q;
                    db_d      = '0;
                    state_d   = DEBOUNCE;
                end else begin
                    col_d   = col_rot;
                    dwell_d = '0;
                end
            end
            DEBOUNCE: begin
                if (row_s_q != row_cap_q) begin
                    dwell_d = '0;
                    state_d = SCAN;
                end else if (db_q == CW'(DB_CYCLES - 1)) begin
                    press_num_d = {row_idx, col_idx};
                    key_held_d  = 1'b1;
                    rel_d       = '0;
                    state_d     = PRESSED;
                end else begin
                    db_d = db_q + 1'b1;
                end
            end
            PRESSED: state_d = RELEASE;
            default: begin
                if (row_s_q != 4'hF) begin
                    rel_d = '0;
                end else if (rel_q == CW'(DB_CYCLES - 1)) begin
                    key_held_d = 1'b0;
                    col_d      = col_rot;
                    dwell_d    = '0;
                    state_d    = SCAN;
                end else begin
                    rel_d = rel_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q      <= 4'hF;
            row_s_q     <= 4'hF;
            state_q     <= SCAN;
            col_q       <= 4'b1110;
            row_cap_q   <= 4'hF;
            press_num_q <= 4'd0;
            key_held_q  <= 1'b0;
            dwell_q     <= '0;
            db_q        <= '0;
            rel_q       <= '0;
        end else begin
            sync_q      <= kp.row;
            row_s_q     <= sync_q;
            state_q     <= state_d;
            col_q       <= col_d;
            row_cap_q   <= row_cap_d;
            press_num_q <= press_num_d;
            key_held_q  <= key_held_d;
            dwell_q     <= dwell_d;
            db_q        <= db_d;
            rel_q       <= rel_d;
        end
    end

    assign kp.col       = col_q;
    assign kp.flag      = (state_q == PRESSED);
    assign kp.press_num = press_num_q;
    assign kp.key_held  = key_held_q;
endmodule

// File: tb/tb_keypad_scan_fsm.sv
// tb_keypad_scan_fsm: randomized keypad presses against a key-matrix model; a scoreboard
// queue holds expected key codes and latencies, a negedge monitor checks every flag.
module tb_keypad_scan_fsm;
    localparam int DWELL = 4;
    localparam int DB    = 20;

    typedef struct {
        int code;
        int lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] keys = 16'h0;
    exp_t        sb[$];
    int          errors = 0, checks = 0, cyc = 0, last_chg = 0, f_run = 0;
    logic        prev_flag = 1'b0, prev_held = 1'b0;
    logic [3:0]  prev_row = 4'hF;

    always #5 clk = ~clk;

    keypad_scan_fsm_if kif();
    keypad_scan_fsm #(.DWELL(DWELL), .DB_CYCLES(DB)) dut (.clk(clk), .rst(rst), .kp(kif.master));

    // key index 4*r+c shorts row r to column c
    function automatic logic [3:0] row_of(logic [15:0] k, logic [3:0] c);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = ~|(k[4*i +: 4] & ~c);
        return r;
    endfunction
    assign kif.row = row_of(keys, kif.col);

    function automatic logic [3:0] rotl(logic [3:0] v, int n);
        for (int i = 0; i < n; i++) v = {v[2:0], v[3]};
        return v;
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_ge(string name, int act, int min);
        checks++;
        if (act < min) begin
            errors++;
            $display("FAIL %s: got %0d expected at least %0d", name, act, min);
        end
    endtask

    task automatic cycles(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_not_col(int c);
        for (int i = 0; i < 8 && kif.col[c] == 1'b0; i++) @(negedge clk);
    endtask

    task automatic wait_release();
        for (int i = 0; i < 80 && kif.key_held; i++) @(negedge clk);
        chk("release_done", kif.key_held, 0);
    endtask

    // press while the key's column is idle so the row edge coincides with the column arriving
    task automatic press_clean(int k, int hold);
        wait_not_col(k % 4);
        keys = 16'h0;
        keys[k] = 1'b1;
        sb.push_back('{k, 2 + (DWELL - 2) + DB});
        cycles(hold);
        chk("held_during_press", kif.key_held, 1);
        keys = 16'h0;
        wait_release();
    endtask

    initial forever begin
        exp_t e;
        @(negedge clk);
        cyc++;
        if (kif.row != prev_row) last_chg = cyc;
        prev_row = kif.row;
        f_run = (kif.row == 4'hF) ? f_run + 1 : 0;
        if (rst) begin
            prev_flag = 1'b0;
            prev_held = 1'b0;
        end else begin
            if (kif.flag) begin
                chk("flag_not_consecutive", prev_flag, 0);
                chk("held_with_flag", kif.key_held, 1);
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_flag: press_num=%0d with no press pending", kif.press_num);
                end else begin
                    e = sb.pop_front();
                    chk("press_num", kif.press_num, e.code);
                    if (e.lat >= 0) chk("flag_latency", cyc - last_chg, e.lat);
                    else chk_ge("flag_after_bounce", cyc - last_chg, DB + 2);
                end
            end
            if (prev_held && !kif.key_held) chk_ge("release_debounce", f_run, DB);
            prev_flag = kif.flag;
            prev_held = kif.key_held;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int changes;
        logic [3:0] last_col;
        rst = 1'b1;
        keys = 16'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_col", kif.col, 4'b1110);
        chk("rst_flag", kif.flag, 0);
        chk("rst_press_num", kif.press_num, 0);
        chk("rst_key_held", kif.key_held, 0);
        rst = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            chk("scan_col", kif.col, rotl(4'b1110, k / DWELL));
        end
        // clean press of key 9, then scanning resumes on the following column
        press_clean(9, 45);
        chk("resume_col", kif.col, 4'b1011);
        cycles(5);
        // bouncing key 3 in 5-cycle segments, then stable
        for (int i = 0; i < 12; i++) begin
            keys[3] = ~keys[3];
            cycles(5);
        end
        keys = 16'h0008;
        sb.push_back('{3, -1});
        cycles(45);
        keys = 16'h0;
        wait_release();
        cycles(5);
        // two keys on column 0: ignored, scanning continues
        keys = 16'h1001;
        changes = 0;
        last_col = kif.col;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (kif.col != last_col) changes++;
            last_col = kif.col;
        end
        chk_ge("multikey_col_rotates", changes, 11);
        keys = 16'h0;
        cycles(5);
        // key 15 held long, then bouncing release
        wait_not_col(3);
        keys = 16'h8000;
        sb.push_back('{15, 2 + (DWELL - 2) + DB});
        cycles(100);
        chk("held_long", kif.key_held, 1);
        for (int i = 0; i < 10; i++) begin
            keys[15] = ~keys[15];
            cycles(1);
        end
        keys = 16'h0;
        wait_release();
        cycles(5);
        // random glitch (too short to debounce) followed by a clean random press
        for (int n = 0; n < 10; n++) begin
            keys = 16'h0;
            keys[$urandom_range(0, 15)] = 1'b1;
            cycles($urandom_range(1, DB - 5));
            keys = 16'h0;
            cycles(6);
            press_clean($urandom_range(0, 15), 50);
            cycles($urandom_range(1, 8));
        end
        // reset in the middle of debouncing key 5, key still held afterwards
        wait_not_col(1);
        keys = 16'h0020;
        for (int i = 0; i < 20 && kif.col != 4'b1101; i++) @(negedge clk);
        cycles(DWELL + 10);
        rst = 1'b1;
        cycles(3);
        chk("midrst_col", kif.col, 4'b1110);
        chk("midrst_flag", kif.flag, 0);
        chk("midrst_press_num", kif.press_num, 0);
        chk("midrst_key_held", kif.key_held, 0);
        sb.push_back('{5, 2 + (DWELL - 2) + DB});
        rst = 1'b0;
        cycles(50);
        keys = 16'h0;
        wait_release();
        cycles(30);
        chk("pending_flags", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
